platform_manager: RTL and testbench



---
 rtl/platform_manager_pkg.sv | 43 ++++
 rtl/platform_manager_lfsr16.sv | 27 ++
 rtl/platform_manager.sv | 156 +++++++++++++++
 tb/tb_platform_manager.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/platform_manager_pkg.sv
// game_pkg: constants, FSM state type, initial platform layout and LFSR
// settings shared by platform_manager and lfsr16.
package game_pkg;

  localparam int unsigned SCREEN_WIDTH  = 400;
  localparam int unsigned SCREEN_HEIGHT = 700;
  localparam int unsigned BLOCK_WIDTH   = 40;
  localparam int unsigned BLOCK_HEIGHT  = 5;
  localparam int unsigned DOODLE_WIDTH  = 20;

  // Legal range of a platform's left edge is [0, X_RANGE).
  localparam int unsigned X_RANGE = SCREEN_WIDTH - BLOCK_WIDTH;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CAMERA = 2'd1,
    SCAN   = 2'd2,
    DONE   = 2'd3
  } state_e;

  function automatic logic [31:0] init_x(int unsigned i);
    if (i == 0) return 32'(SCREEN_WIDTH / 2 - BLOCK_WIDTH / 2);
    return 32'((i * 73) % X_RANGE);
  endfunction

  function automatic logic [31:0] init_y(int unsigned i, int unsigned num_blocks);
    return 32'(i * (SCREEN_HEIGHT / num_blocks));
  endfunction

  // Maps the low 9 LFSR bits into [0, X_RANGE). One subtraction is enough
  // because X_RANGE is constrained to [256, 511].
  function automatic logic [31:0] fold(logic [15:0] v);
    logic [31:0] low;
    low = {23'd0, v[8:0]};
    if (low >= 32'(X_RANGE)) return low - 32'(X_RANGE);
    return low;
  endfunction

endpackage

// File: rtl/platform_manager_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR that advances only when step is high.
// Ports: clk, reset (async, active-high, reloads the seed), step, value.
module lfsr16
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  output logic [15:0] value
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (step) lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;

endmodule

// File: rtl/platform_manager.sv
// platform_manager: owns the platform field, scrolls the camera and
// answers the doodle's collision query once per physics tick.
// Ports:
//   clk, reset        - clock, async active-high reset
//   physicsUpdate     - async physics tick (synchronised here)
//   doodleX, doodleY  - doodle world position, snapshotted per tick
//   rdIndex/rdX/rdY   - registered platform read port (1-cycle latency)
//   hasCollide        - result of the most recent scan, held between scans
//   cameraY           - world Y of the screen bottom, never decreases
//   scanDone          - 1-cycle pulse when hasCollide is refreshed
//   gameOver          - sticky, set when the doodle falls below the camera
// Tick protocol: one tick is accepted in IDLE; a single tick arriving while
// busy is remembered and served next, any further ones are dropped.
module platform_manager
  import game_pkg::*;
#(
  parameter  int unsigned NUM_BLOCKS  = 8,
  parameter  int unsigned SCROLL_LINE = 350,
  localparam int unsigned IW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          physicsUpdate,
  input  logic [31:0]   doodleX,
  input  logic [31:0]   doodleY,
  input  logic [IW-1:0] rdIndex,
  output logic [31:0]   rdX,
  output logic [31:0]   rdY,
  output logic          hasCollide,
  output logic [31:0]   cameraY,
  output logic          scanDone,
  output logic          gameOver
);

  if ((X_RANGE < 256) || (X_RANGE > 511)) begin : g_bad_x_range
    $error("SCREEN_WIDTH - BLOCK_WIDTH must lie in [256, 511]");
  end

  state_e        state_q, state_d;
  logic          sync1_q, sync2_q, prev_q, pending_q;
  logic [31:0]   sx_q, sy_q, cam_q;
  logic          acc_q, hit_q, done_q, over_q;
  logic [IW-1:0] idx_q;
  logic [31:0]   rdx_q, rdy_q;
  logic [31:0]   bx_q [NUM_BLOCKS];
  logic [31:0]   by_q [NUM_BLOCKS];
  logic [15:0]   lfsr_val;

  logic          tick;
  logic [31:0]   cur_x, cur_y;
  logic          respawn, overlap, hit, last;

  assign tick = sync2_q & ~prev_q;

  assign cur_x   = bx_q[idx_q];
  assign cur_y   = by_q[idx_q];
  // cam_q already holds the camera written in CAMERA.
  assign respawn = (cur_y + 32'(BLOCK_HEIGHT)) < cam_q;
  assign overlap = (sx_q < cur_x + 32'(BLOCK_WIDTH)) &&
                   (sx_q + 32'(DOODLE_WIDTH) > cur_x) &&
                   (cur_y <= sy_q) && (sy_q <= cur_y + 32'(BLOCK_HEIGHT));
  // A platform being respawned this cycle is no longer where it was tested.
  assign hit     = overlap && !respawn;
  assign last    = (idx_q == IW'(NUM_BLOCKS - 1));

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  ((state_q == SCAN) && respawn),
    .value (lfsr_val)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick || pending_q) state_d = CAMERA;
      CAMERA:  state_d = SCAN;
      SCAN:    if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      pending_q <= 1'b0;
      sx_q      <= '0;
      sy_q      <= '0;
      cam_q     <= '0;
      acc_q     <= 1'b0;
      hit_q     <= 1'b0;
      done_q    <= 1'b0;
      over_q    <= 1'b0;
      idx_q     <= '0;
      rdx_q     <= '0;
      rdy_q     <= '0;
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        bx_q[i] <= init_x(i);
        by_q[i] <= init_y(i, NUM_BLOCKS);
      end
    end else begin
      sync1_q <= physicsUpdate;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      done_q  <= 1'b0;
      // Non-blocking read: a same-cycle rewrite returns the old value.
      rdx_q   <= bx_q[rdIndex];
      rdy_q   <= by_q[rdIndex];

      if (state_q == IDLE)  pending_q <= 1'b0;
      else if (tick)        pending_q <= 1'b1;

      case (state_q)
        CAMERA: begin
          sx_q <= doodleX;
          sy_q <= doodleY;
          if (doodleY > cam_q + 32'(SCROLL_LINE)) cam_q <= doodleY - 32'(SCROLL_LINE);
          if (doodleY < cam_q) over_q <= 1'b1;
          acc_q <= 1'b0;
          idx_q <= '0;
        end
        SCAN: begin
          if (respawn) begin
            by_q[idx_q] <= cur_y + 32'(SCREEN_HEIGHT);
            bx_q[idx_q] <= fold(lfsr_val);
          end
          acc_q <= acc_q | hit;
          idx_q <= idx_q + 1'b1;
          // Result is published on entry to DONE so scanDone and the new
          // hasCollide are visible in the same cycle.
          if (last) begin
            hit_q  <= acc_q | hit;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rdX        = rdx_q;
  assign rdY        = rdy_q;
  assign hasCollide = hit_q;
  assign cameraY    = cam_q;
  assign scanDone   = done_q;
  assign gameOver   = over_q;

endmodule

// File: tb/tb_platform_manager.sv
module tb_platform_manager;

  localparam int NB = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        physicsUpdate = 1'b0;
  logic [31:0] doodleX = '0;
  logic [31:0] doodleY = '0;
  logic [2:0]  rdIndex = '0;
  logic [31:0] rdX, rdY, cameraY;
  logic        hasCollide, scanDone, gameOver;

  int checks = 0;
  int errors = 0;
  int last_latency = 0;

  platform_manager dut (
    .clk(clk), .reset(reset), .physicsUpdate(physicsUpdate),
    .doodleX(doodleX), .doodleY(doodleY), .rdIndex(rdIndex),
    .rdX(rdX), .rdY(rdY), .hasCollide(hasCollide), .cameraY(cameraY),
    .scanDone(scanDone), .gameOver(gameOver)
  );

  always #5 clk = ~clk;

  // Reference model: the game rules applied to whole ticks.
  logic [31:0] m_x [NB];
  logic [31:0] m_y [NB];
  logic [31:0] m_cam;
  logic [15:0] m_lfsr;
  bit          m_go, m_col;

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) begin
      m_x[i] = (i == 0) ? 32'd180 : 32'((i * 73) % 360);
      m_y[i] = 32'(i * (700 / NB));
    end
    m_cam = 0; m_go = 0; m_col = 0; m_lfsr = 16'hACE1;
  endfunction

  function automatic void model_tick(logic [31:0] x, logic [31:0] y);
    if (y < m_cam) m_go = 1;
    if (y > m_cam + 350) m_cam = y - 350;
    m_col = 0;
    for (int i = 0; i < NB; i++) begin
      if (m_y[i] + 5 < m_cam) begin
        m_y[i] = m_y[i] + 700;
        m_x[i] = 32'(int'(m_lfsr & 16'h01FF) % 360);
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      end else if (x < m_x[i] + 40 && x + 20 > m_x[i] && y >= m_y[i] && y <= m_y[i] + 5) begin
        m_col = 1;
      end
    end
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One physics edge, then wait (bounded) for the scan to finish.
  task automatic do_tick(input logic [31:0] x, input logic [31:0] y);
    int k;
    bit seen;
    @(negedge clk);
    doodleX = x; doodleY = y; physicsUpdate = 1'b1;
    k = 0; seen = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 2) physicsUpdate = 1'b0;
      if (scanDone) seen = 1;
    end
    last_latency = k;
    model_tick(x, y);
    if (!seen) begin
      checks++; errors++;
      $display("FAIL scan_timeout: no scanDone within %0d cycles", k);
    end
  endtask

  task automatic read_plat(input int i, output logic [31:0] x, output logic [31:0] y);
    @(negedge clk);
    rdIndex = 3'(i);
    @(negedge clk);
    x = rdX; y = rdY;
  endtask

  task automatic test_reset();
    logic [31:0] x, y;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({hasCollide, scanDone, gameOver} !== 3'b000 || cameraY !== 32'd0 || rdX !== 0 || rdY !== 0) begin
      errors++;
      $display("FAIL reset_outputs: col=%0b done=%0b go=%0b cam=%0d rd=(%0d,%0d) want all 0",
               hasCollide, scanDone, gameOver, cameraY, rdX, rdY);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NB; i++) begin
      read_plat(i, x, y);
      checks++;
      if (x !== m_x[i] || y !== m_y[i]) begin
        errors++;
        $display("FAIL reset_layout[%0d]: got (%0d,%0d) want (%0d,%0d)", i, x, y, m_x[i], m_y[i]);
      end
    end
  endtask

  task automatic test_collide();
    logic [31:0] px [3];
    logic [31:0] py [3];
    bit          want [3];
    px[0] = 200; py[0] = 0;  want[0] = 1;
    px[1] = 300; py[1] = 40; want[1] = 0;
    px[2] = 80;  py[2] = 89; want[2] = 1;
    for (int t = 0; t < 3; t++) begin
      do_tick(px[t], py[t]);
      checks++;
      if (hasCollide !== want[t] || hasCollide !== m_col || cameraY !== 32'd0) begin
        errors++;
        $display("FAIL collide[%0d]: col=%0b cam=%0d want col=%0b cam=0", t, hasCollide, cameraY, want[t]);
      end
    end
    checks++;
    if (last_latency != 12) begin
      errors++;
      $display("FAIL tick_latency: got %0d cycles want 12", last_latency);
    end
  endtask

  task automatic test_camera();
    logic [31:0] x, y;
    do_tick(200, 500);
    checks++;
    if (cameraY !== 32'd150 || cameraY !== m_cam || hasCollide !== m_col || gameOver !== 1'b0) begin
      errors++;
      $display("FAIL camera: cam=%0d col=%0b go=%0b want cam=150 col=%0b go=0", cameraY, hasCollide, gameOver, m_col);
    end
    for (int i = 0; i < NB; i++) begin
      read_plat(i, x, y);
      checks++;
      if (x !== m_x[i] || y !== m_y[i]) begin
        errors++;
        $display("FAIL respawn[%0d]: got (%0d,%0d) want (%0d,%0d)", i, x, y, m_x[i], m_y[i]);
      end
    end
    checks++;
    if (m_y[0] !== 32'd700 || m_y[1] !== 32'd787) begin
      errors++;
      $display("FAIL respawn_y_model: model y0=%0d y1=%0d want 700 787", m_y[0], m_y[1]);
    end
  endtask

  task automatic test_gameover();
    do_tick(200, 100);
    checks++;
    if (gameOver !== 1'b1 || cameraY !== m_cam || hasCollide !== m_col) begin
      errors++;
      $display("FAIL gameover_set: go=%0b cam=%0d col=%0b want go=1 cam=%0d col=%0b",
               gameOver, cameraY, hasCollide, m_cam, m_col);
    end
    do_tick(200, 400);
    do_tick(50, 600);
    checks++;
    if (gameOver !== 1'b1 || cameraY !== m_cam || hasCollide !== m_col) begin
      errors++;
      $display("FAIL gameover_sticky: go=%0b cam=%0d col=%0b want go=1 cam=%0d col=%0b",
               gameOver, cameraY, hasCollide, m_cam, m_col);
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    apply_reset();
    @(negedge clk);
    doodleX = 200; doodleY = 2;
    pulses = 0;
    for (int c = 0; c < 45; c++) begin
      physicsUpdate = (c == 0 || c == 3 || c == 6) ? 1'b1 : 1'b0;
      @(negedge clk);
      if (scanDone) pulses++;
    end
    physicsUpdate = 1'b0;
    model_tick(200, 2);
    model_tick(200, 2);
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL back_to_back_pulses: got %0d want 2", pulses);
    end
    checks++;
    if (hasCollide !== m_col || cameraY !== m_cam) begin
      errors++;
      $display("FAIL back_to_back_state: col=%0b cam=%0d want col=%0b cam=%0d", hasCollide, cameraY, m_col, m_cam);
    end
  endtask

  task automatic test_random();
    logic [31:0] x, y;
    int j;
    apply_reset();
    for (int t = 0; t < 16; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        j = $urandom_range(0, NB - 1);
        x = m_x[j] + $urandom_range(0, 50);
        y = m_y[j] + $urandom_range(0, 7);
      end else begin
        x = $urandom_range(0, 399);
        y = m_cam + $urandom_range(0, 600);
      end
      do_tick(x, y);
      checks++;
      if (hasCollide !== m_col || cameraY !== m_cam || gameOver !== m_go) begin
        errors++;
        $display("FAIL random[%0d] (%0d,%0d): col=%0b cam=%0d go=%0b want col=%0b cam=%0d go=%0b",
                 t, x, y, hasCollide, cameraY, gameOver, m_col, m_cam, m_go);
      end
    end
    for (int i = 0; i < NB; i++) begin
      read_plat(i, x, y);
      checks++;
      if (x !== m_x[i] || y !== m_y[i]) begin
        errors++;
        $display("FAIL random_layout[%0d]: got (%0d,%0d) want (%0d,%0d)", i, x, y, m_x[i], m_y[i]);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [31:0] x, y;
    // Push the camera up first so the aborted scan would have respawned.
    do_tick(100, 900);
    @(negedge clk);
    doodleX = 100; doodleY = 1500; physicsUpdate = 1'b1;
    repeat (6) @(negedge clk);
    physicsUpdate = 1'b0;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({hasCollide, scanDone, gameOver} !== 3'b000 || cameraY !== 32'd0 || rdX !== 0 || rdY !== 0) begin
      errors++;
      $display("FAIL mid_scan_reset: col=%0b done=%0b go=%0b cam=%0d rd=(%0d,%0d) want all 0",
               hasCollide, scanDone, gameOver, cameraY, rdX, rdY);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    read_plat(0, x, y);
    checks++;
    if (x !== 32'd180 || y !== 32'd0) begin
      errors++;
      $display("FAIL mid_scan_plat0: got (%0d,%0d) want (180,0)", x, y);
    end
    read_plat(7, x, y);
    checks++;
    if (x !== 32'd151 || y !== 32'd609) begin
      errors++;
      $display("FAIL mid_scan_plat7: got (%0d,%0d) want (151,609)", x, y);
    end
  endtask

  initial begin
    test_reset();
    test_collide();
    test_camera();
    test_gameover();
    test_back_to_back();
    test_random();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
